// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
// Shares one AXI read channel (AR/R) between the instruction-side and
// data-side miss paths. Only one read burst is outstanding at a time, so
// returned beats are steered by the latched grant and never reordered.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   inst_rd_req/addr/len       instruction-side read request (len = beats-1)
//   inst_rd_addr_ok            pulse when the instruction request is accepted
//   inst_ret_valid/last        returned beat strobe / final beat, inst side
//   data_rd_req/addr/len       data-side read request
//   data_rd_addr_ok            pulse when the data request is accepted
//   data_ret_valid/last        returned beat strobe / final beat, data side
//   ret_rdata                  beat data, shared, qualified by *_ret_valid
//   arid..arvalid, arready     AXI AR channel
//   rid, rdata, rlast, rvalid  AXI R channel inputs
//   rready                     AXI R ready
//   proto_err                  sticky: rid mismatch or rlast/beat-count disagreement
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transaction; arbitrate and latch the winning request
// ADDR  | arvalid high from latched registers, waiting for arready
// DATA  | rready high, forwarding beats to the granted side until rlast

module mem_read_arbiter #(
   parameter logic [3:0] INST_ARID = 4'd0,
   parameter logic [3:0] DATA_ARID = 4'd1
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        inst_rd_req,
   input  logic [31:0] inst_rd_addr,
   input  logic [3:0]  inst_rd_len,
   output logic        inst_rd_addr_ok,
   output logic        inst_ret_valid,
   output logic        inst_ret_last,

   input  logic        data_rd_req,
   input  logic [31:0] data_rd_addr,
   input  logic [3:0]  data_rd_len,
   output logic        data_rd_addr_ok,
   output logic        data_ret_valid,
   output logic        data_ret_last,

   output logic [31:0] ret_rdata,

   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,

   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,

   output logic        proto_err
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   localparam logic SIDE_INST = 1'b0;
   localparam logic SIDE_DATA = 1'b1;

   state_t      state_q, state_d;
   logic        grant_q, grant_d;
   logic        last_grant_q, last_grant_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  len_q, len_d;
   logic [3:0]  id_q, id_d;
   logic [3:0]  beat_cnt_q, beat_cnt_d;
   logic        arvalid_q, arvalid_d;
   logic        rready_q, rready_d;
   logic        proto_err_q, proto_err_d;

   logic        pick;
   logic        ar_hs;
   logic        beat;

   assign ar_hs = (state_q == ADDR) && arvalid_q && arready;
   assign beat  = (state_q == DATA) && rvalid;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      len_d        = len_q;
      id_d         = id_q;
      beat_cnt_d   = beat_cnt_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      proto_err_d  = proto_err_q;
      pick         = SIDE_INST;

      case (state_q)
         IDLE: begin
            if (inst_rd_req || data_rd_req) begin
               // On a tie the side that did not win last time goes first.
               if (inst_rd_req && data_rd_req) pick = ~last_grant_q;
               else                            pick = data_rd_req ? SIDE_DATA : SIDE_INST;
               grant_d      = pick;
               last_grant_d = pick;
               addr_d       = (pick == SIDE_DATA) ? data_rd_addr : inst_rd_addr;
               len_d        = (pick == SIDE_DATA) ? data_rd_len  : inst_rd_len;
               id_d         = (pick == SIDE_DATA) ? DATA_ARID    : INST_ARID;
               arvalid_d    = 1'b1;
               state_d      = ADDR;
            end
         end
         ADDR: begin
            if (ar_hs) begin
               arvalid_d  = 1'b0;
               rready_d   = 1'b1;
               beat_cnt_d = 4'd0;
               state_d    = DATA;
            end
         end
         DATA: begin
            if (beat) begin
               beat_cnt_d = beat_cnt_q + 4'd1;
               // beat_cnt_q is the index of the beat arriving now.
               if (rid != id_q)                    proto_err_d = 1'b1;
               if (rlast  && (beat_cnt_q != len_q)) proto_err_d = 1'b1;
               if (!rlast && (beat_cnt_q == len_q)) proto_err_d = 1'b1;
               if (rlast) begin
                  rready_d = 1'b0;
                  state_d  = IDLE;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= SIDE_INST;
         last_grant_q <= SIDE_DATA;
         addr_q       <= 32'd0;
         len_q        <= 4'd0;
         id_q         <= 4'd0;
         beat_cnt_q   <= 4'd0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         proto_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         id_q         <= id_d;
         beat_cnt_q   <= beat_cnt_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         proto_err_q  <= proto_err_d;
      end
   end

   assign arid    = id_q;
   assign araddr  = addr_q;
   assign arlen   = {4'b0, len_q};
   assign arsize  = 3'd2;
   assign arburst = 2'b01;
   assign arvalid = arvalid_q;
   assign rready  = rready_q;

   assign inst_rd_addr_ok = ar_hs && (grant_q == SIDE_INST);
   assign data_rd_addr_ok = ar_hs && (grant_q == SIDE_DATA);

   assign inst_ret_valid = beat && (grant_q == SIDE_INST);
   assign data_ret_valid = beat && (grant_q == SIDE_DATA);
   assign inst_ret_last  = inst_ret_valid && rlast;
   assign data_ret_last  = data_ret_valid && rlast;
   assign ret_rdata      = rdata;

   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
module tb_mem_read_arbiter;

   logic        clk;
   logic        reset;
   logic        inst_rd_req;
   logic [31:0] inst_rd_addr;
   logic [3:0]  inst_rd_len;
   logic        inst_rd_addr_ok;
   logic        inst_ret_valid;
   logic        inst_ret_last;
   logic        data_rd_req;
   logic [31:0] data_rd_addr;
   logic [3:0]  data_rd_len;
   logic        data_rd_addr_ok;
   logic        data_ret_valid;
   logic        data_ret_last;
   logic [31:0] ret_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic        proto_err;

   mem_read_arbiter dut (
      .clk(clk), .reset(reset),
      .inst_rd_req(inst_rd_req), .inst_rd_addr(inst_rd_addr), .inst_rd_len(inst_rd_len),
      .inst_rd_addr_ok(inst_rd_addr_ok), .inst_ret_valid(inst_ret_valid), .inst_ret_last(inst_ret_last),
      .data_rd_req(data_rd_req), .data_rd_addr(data_rd_addr), .data_rd_len(data_rd_len),
      .data_rd_addr_ok(data_rd_addr_ok), .data_ret_valid(data_ret_valid), .data_ret_last(data_ret_last),
      .ret_rdata(ret_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] IA = 32'h1FC0_0000;
   localparam logic [31:0] DA = 32'h8000_0040;

   // in = {reset, inst_req, data_req, arready, rvalid, rlast}
   // ex = {arvalid, inst_ok, data_ok, inst_ret, data_ret, ret_last, rready, proto_err}
   typedef struct {
      logic [5:0]  in;
      logic [3:0]  rid;
      logic [31:0] rdat;
      logic [7:0]  ex;
      logic [3:0]  arid;
      logic [31:0] erd;
   } vec_t;

   vec_t tbl[23];

   task automatic chk1(input string nm, input logic act, input logic want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, want, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, want, $time);
      end
   endtask

   task automatic fail_bound(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: bound expired, got no event, expected one (t=%0t)", nm, $time);
   endtask

   task automatic idle_inputs();
      inst_rd_req = 1'b0;
      data_rd_req = 1'b0;
      arready     = 1'b0;
      rvalid      = 1'b0;
      rlast       = 1'b0;
      rid         = 4'd0;
      rdata       = 32'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Waits for the AR request of the given side and checks its fields.
   task automatic wait_ar(input logic side, input logic [31:0] addr, input logic [7:0] len);
      bit seen;
      seen    = 1'b0;
      arready = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (arvalid) begin
            seen = 1'b1;
            chk32("ar_id", 32'(arid), 32'(side));
            chk32("ar_addr", araddr, addr);
            chk32("ar_len", 32'(arlen), 32'(len));
            chk1("ar_inst_ok", inst_rd_addr_ok, !side);
            chk1("ar_data_ok", data_rd_addr_ok, side);
         end
         @(posedge clk); #1;
      end
      arready = 1'b0;
      if (!seen) fail_bound("ar_wait");
   endtask

   task automatic send_beats(input int n, input logic [3:0] id, input logic side, input logic last_end);
      logic [31:0] d;
      for (int i = 0; i < n; i++) begin
         d      = $urandom;
         rvalid = 1'b1;
         rid    = id;
         rdata  = d;
         rlast  = last_end && (i == n - 1);
         @(negedge clk);
         chk1("beat_inst_v", inst_ret_valid, !side);
         chk1("beat_data_v", data_ret_valid, side);
         chk32("beat_data", ret_rdata, d);
         chk1("beat_last", inst_ret_last | data_ret_last, rlast);
         chk1("beat_rready", rready, 1'b1);
         @(posedge clk); #1;
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
   endtask

   // Random-test state: requesters, transaction-level reference model, slave.
   bit          s_req[2];
   logic [31:0] s_addr[2];
   logic [3:0]  s_len[2];
   int          s_left[2];
   int          done_cnt[2];
   bit          m_ar, m_data, m_side, m_last, pk;
   logic [31:0] m_addr;
   logic [3:0]  m_len;
   bit          sl_act;
   int          sl_idx;
   logic [3:0]  sl_len, sl_id;
   logic [31:0] r_d;
   int          cyc;
   localparam int NTX = 40;

   initial begin
      reset = 1'b1;
      idle_inputs();
      inst_rd_addr = IA;  inst_rd_len = 4'd3;
      data_rd_addr = DA;  data_rd_len = 4'd0;

      tbl[0]  = '{6'b100000, 4'd0, 32'h00, 8'b00000000, 4'd0, 32'h00};
      tbl[1]  = '{6'b000000, 4'd0, 32'h00, 8'b00000000, 4'd0, 32'h00};
      tbl[2]  = '{6'b010100, 4'd0, 32'h00, 8'b00000000, 4'd0, 32'h00};
      tbl[3]  = '{6'b010100, 4'd0, 32'h00, 8'b11000000, 4'd0, 32'h00};
      tbl[4]  = '{6'b000010, 4'd0, 32'hA0, 8'b00010010, 4'd0, 32'hA0};
      tbl[5]  = '{6'b000010, 4'd0, 32'hA1, 8'b00010010, 4'd0, 32'hA1};
      tbl[6]  = '{6'b000000, 4'd0, 32'h00, 8'b00000010, 4'd0, 32'h00};
      tbl[7]  = '{6'b000010, 4'd0, 32'hA2, 8'b00010010, 4'd0, 32'hA2};
      tbl[8]  = '{6'b000011, 4'd0, 32'hA3, 8'b00010110, 4'd0, 32'hA3};
      tbl[9]  = '{6'b000000, 4'd0, 32'h00, 8'b00000000, 4'd0, 32'h00};
      tbl[10] = '{6'b001000, 4'd0, 32'h00, 8'b00000000, 4'd0, 32'h00};
      tbl[11] = '{6'b001000, 4'd0, 32'h00, 8'b10000000, 4'd1, 32'h00};
      tbl[12] = '{6'b011000, 4'd0, 32'h00, 8'b10000000, 4'd1, 32'h00};
      tbl[13] = '{6'b011100, 4'd0, 32'h00, 8'b10100000, 4'd1, 32'h00};
      tbl[14] = '{6'b010000, 4'd0, 32'h00, 8'b00000010, 4'd0, 32'h00};
      tbl[15] = '{6'b010011, 4'd1, 32'h55, 8'b00001110, 4'd0, 32'h55};
      tbl[16] = '{6'b010100, 4'd0, 32'h00, 8'b00000000, 4'd0, 32'h00};
      tbl[17] = '{6'b010100, 4'd0, 32'h00, 8'b11000000, 4'd0, 32'h00};
      tbl[18] = '{6'b000010, 4'd1, 32'h77, 8'b00010010, 4'd0, 32'h77};
      tbl[19] = '{6'b000011, 4'd0, 32'h78, 8'b00010111, 4'd0, 32'h78};
      tbl[20] = '{6'b000000, 4'd0, 32'h00, 8'b00000001, 4'd0, 32'h00};
      tbl[21] = '{6'b100000, 4'd0, 32'h00, 8'b00000001, 4'd0, 32'h00};
      tbl[22] = '{6'b000000, 4'd0, 32'h00, 8'b00000000, 4'd0, 32'h00};

      // ---- table-driven directed vectors ----
      for (int i = 0; i < 23; i++) begin
         reset       = tbl[i].in[5];
         inst_rd_req = tbl[i].in[4];
         data_rd_req = tbl[i].in[3];
         arready     = tbl[i].in[2];
         rvalid      = tbl[i].in[1];
         rlast       = tbl[i].in[0];
         rid         = tbl[i].rid;
         rdata       = tbl[i].rdat;
         @(negedge clk);
         chk1("t_arvalid",   arvalid,         tbl[i].ex[7]);
         chk1("t_inst_ok",   inst_rd_addr_ok, tbl[i].ex[6]);
         chk1("t_data_ok",   data_rd_addr_ok, tbl[i].ex[5]);
         chk1("t_inst_ret",  inst_ret_valid,  tbl[i].ex[4]);
         chk1("t_data_ret",  data_ret_valid,  tbl[i].ex[3]);
         chk1("t_ret_last",  inst_ret_last | data_ret_last, tbl[i].ex[2]);
         chk1("t_rready",    rready,          tbl[i].ex[1]);
         chk1("t_proto_err", proto_err,       tbl[i].ex[0]);
         if (tbl[i].ex[7]) begin
            chk32("t_arid",    32'(arid),    32'(tbl[i].arid));
            chk32("t_araddr",  araddr,       (tbl[i].arid == 4'd0) ? IA : DA);
            chk32("t_arlen",   32'(arlen),   (tbl[i].arid == 4'd0) ? 32'd3 : 32'd0);
            chk32("t_arsize",  32'(arsize),  32'd2);
            chk32("t_arburst", 32'(arburst), 32'd1);
         end
         if (tbl[i].ex[4] | tbl[i].ex[3]) chk32("t_rdata", ret_rdata, tbl[i].erd);
         @(posedge clk); #1;
      end

      // ---- both sides requesting continuously: strict alternation, inst first ----
      do_reset();
      inst_rd_addr = 32'h0000_1000; inst_rd_len = 4'd1;
      data_rd_addr = 32'h0000_2000; data_rd_len = 4'd0;
      inst_rd_req = 1'b1; data_rd_req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) begin
            wait_ar(1'b0, 32'h0000_1000, 8'd1);
            send_beats(2, 4'd0, 1'b0, 1'b1);
         end else begin
            wait_ar(1'b1, 32'h0000_2000, 8'd0);
            send_beats(1, 4'd1, 1'b1, 1'b1);
         end
      end
      inst_rd_req = 1'b0; data_rd_req = 1'b0;
      @(negedge clk);
      chk1("alt_proto_err", proto_err, 1'b0);
      @(posedge clk); #1;

      // ---- reset in the middle of a burst ----
      do_reset();
      inst_rd_addr = IA; inst_rd_len = 4'd3;
      inst_rd_req = 1'b1;
      wait_ar(1'b0, IA, 8'd3);
      inst_rd_req = 1'b0;
      send_beats(1, 4'd5, 1'b0, 1'b0);
      send_beats(1, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk1("mid_perr_set", proto_err, 1'b1);
      chk1("mid_rready",   rready,    1'b1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk1("rst_arvalid", arvalid,   1'b0);
      chk1("rst_rready",  rready,    1'b0);
      chk1("rst_perr",    proto_err, 1'b0);
      @(posedge clk); #1;
      data_rd_addr = 32'h8000_0100; data_rd_len = 4'd0;
      data_rd_req = 1'b1;
      wait_ar(1'b1, 32'h8000_0100, 8'd0);
      data_rd_req = 1'b0;
      send_beats(1, 4'd1, 1'b1, 1'b1);
      @(negedge clk);
      chk1("fresh_rready", rready,    1'b0);
      chk1("fresh_perr",   proto_err, 1'b0);
      @(posedge clk); #1;

      // ---- final beat without rlast: error, FSM keeps waiting for rlast ----
      do_reset();
      data_rd_addr = 32'h0000_3000; data_rd_len = 4'd0;
      data_rd_req = 1'b1;
      wait_ar(1'b1, 32'h0000_3000, 8'd0);
      data_rd_req = 1'b0;
      send_beats(1, 4'd1, 1'b1, 1'b0);
      @(negedge clk);
      chk1("nolast_perr",   proto_err, 1'b1);
      chk1("nolast_rready", rready,    1'b1);
      @(posedge clk); #1;
      send_beats(1, 4'd1, 1'b1, 1'b1);
      @(negedge clk);
      chk1("nolast_done_rready", rready,    1'b0);
      chk1("nolast_sticky",      proto_err, 1'b1);
      @(posedge clk); #1;

      // ---- randomized traffic against a transaction-level model ----
      do_reset();
      for (int s = 0; s < 2; s++) begin
         s_req[s] = 1'b0; s_left[s] = NTX; done_cnt[s] = 0;
         s_addr[s] = 32'd0; s_len[s] = 4'd0;
      end
      m_ar = 1'b0; m_data = 1'b0; m_side = 1'b0; m_last = 1'b1;
      m_addr = 32'd0; m_len = 4'd0;
      sl_act = 1'b0; sl_idx = 0; sl_len = 4'd0; sl_id = 4'd0;
      cyc = 0;
      while (cyc < 20000 && !(done_cnt[0] == NTX && done_cnt[1] == NTX)) begin
         for (int s = 0; s < 2; s++) begin
            if (!s_req[s] && s_left[s] > 0 && $urandom_range(0, 3) != 0) begin
               s_req[s]  = 1'b1;
               s_left[s] = s_left[s] - 1;
               s_addr[s] = $urandom & 32'hFFFF_FFFC;
               s_len[s]  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                       : 4'($urandom_range(0, 3));
            end
         end
         inst_rd_req = s_req[0]; inst_rd_addr = s_addr[0]; inst_rd_len = s_len[0];
         data_rd_req = s_req[1]; data_rd_addr = s_addr[1]; data_rd_len = s_len[1];
         arready = ($urandom_range(0, 2) != 0);
         r_d   = $urandom;
         rdata = r_d;
         if (sl_act && $urandom_range(0, 3) != 0) begin
            rvalid = 1'b1;
            rid    = sl_id;
            rlast  = (sl_idx == int'(sl_len));
         end else begin
            rvalid = 1'b0;
            rlast  = 1'b0;
            rid    = 4'($urandom_range(0, 15));
         end

         @(negedge clk);
         chk1("r_arvalid", arvalid, m_ar);
         if (m_ar) begin
            chk32("r_arid",   32'(arid),  32'(m_side));
            chk32("r_araddr", araddr,     m_addr);
            chk32("r_arlen",  32'(arlen), 32'(m_len));
         end
         chk1("r_inst_ok",  inst_rd_addr_ok, m_ar && arready && !m_side);
         chk1("r_data_ok",  data_rd_addr_ok, m_ar && arready &&  m_side);
         chk1("r_rready",   rready,          m_data);
         chk1("r_inst_ret", inst_ret_valid,  m_data && rvalid && !m_side);
         chk1("r_data_ret", data_ret_valid,  m_data && rvalid &&  m_side);
         if (m_data && rvalid) begin
            chk32("r_rdata", ret_rdata, r_d);
            chk1("r_last", inst_ret_last | data_ret_last, rlast);
         end
         chk1("r_proto_err", proto_err, 1'b0);

         if (m_data && rvalid) begin
            sl_idx = sl_idx + 1;
            if (rlast) begin
               m_data = 1'b0;
               sl_act = 1'b0;
               done_cnt[m_side] = done_cnt[m_side] + 1;
            end
         end else if (m_ar && arready) begin
            m_ar   = 1'b0;
            m_data = 1'b1;
            s_req[m_side] = 1'b0;
            sl_act = 1'b1;
            sl_idx = 0;
            sl_len = m_len;
            sl_id  = 4'(m_side);
         end else if (!m_ar && !m_data && (s_req[0] || s_req[1])) begin
            if (s_req[0] && s_req[1]) pk = !m_last;
            else                      pk = s_req[1];
            m_ar   = 1'b1;
            m_side = pk;
            m_last = pk;
            m_addr = s_addr[pk];
            m_len  = s_len[pk];
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (cyc >= 20000) fail_bound("random_traffic");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
